// File: rtl/if_id_buffer.sv
// Purpose : elastic {pc, inst} buffer between fetch and decode; flush discards wrong-path words.
// Latency : a word pushed at edge N is presented to decode in cycle N+1; one word/cycle sustained.
// Backpr. : registered stall when full; a push in a full cycle is rejected even if decode pops.
//
// Ports:
//   clk, rst (async, active-low)     flush (taken jump, discards all in-flight entries)
//   in_valid/in_pc/in_inst (fetch)   stall (to fetch, buffer full)
//   out_valid/out_pc/out_inst/out_ready (decode handshake; data zeroed when not valid)
//   count (occupancy), drop_cnt (saturating count of entries discarded by flush)
module if_id_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int DROP_W = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_inst,
   output logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_inst,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  count,
   output logic [DROP_W-1:0] drop_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] inst;
   } entry_t;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wp;
   logic [PTR_W-1:0]   rp;
   logic               stall_q;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [CNT_W-1:0]   count_nxt;
   logic [DROP_W:0]    drop_sum;
   logic [DROP_W-1:0]  drop_sat;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Push decision uses the occupancy before the edge, so a pop in the same
   // cycle never frees room for a push; this keeps out_ready off the stall path.
   assign push = in_valid & ~full & ~flush;
   assign pop  = out_valid & out_ready & ~flush;

   assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

   // One extra bit catches the carry so the drop counter can clamp at all-ones.
   assign drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(count);
   assign drop_sat = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         stall_q  <= 1'b0;
         drop_cnt <= '0;
      end else if (flush) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         stall_q  <= 1'b0;
         drop_cnt <= drop_sat;
      end else begin
         if (push) wp <= wp + PTR_W'(1);
         if (pop)  rp <= rp + PTR_W'(1);
         count   <= count_nxt;
         stall_q <= (count_nxt == FULL_CNT);
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= '{pc: in_pc, inst: in_inst};
   end

   assign stall     = stall_q;
   assign out_valid = ~empty;
   assign out_pc    = out_valid ? mem[rp].pc   : '0;
   assign out_inst  = out_valid ? mem[rp].inst : '0;

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;

   localparam int DEPTH    = 2;
   localparam int DROP_MAX = 255;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        out_ready = 1'b0;
   logic        stall;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [1:0]  count;
   logic [7:0]  drop_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: expected contents in arrival order plus expected drop total.
   ent_t exp_q[$];
   int   drop_m = 0;

   if_id_buffer #(.DATA_W(32), .DEPTH(DEPTH), .DROP_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
      .stall(stall),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
      .out_ready(out_ready),
      .count(count), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor / scoreboard: compares outputs to the model mid-cycle, then
   // applies this cycle's inputs to the model for the coming edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_stall",     32'(stall),     32'd0);
         chk("rst_count",     32'(count),     32'd0);
         chk("rst_out_pc",    out_pc,         32'd0);
         chk("rst_out_inst",  out_inst,       32'd0);
         chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
         exp_q.delete();
         drop_m = 0;
      end else begin
         int had;
         had = exp_q.size();
         chk("out_valid", 32'(out_valid), 32'(had != 0));
         chk("count",     32'(count),     32'(had));
         chk("stall",     32'(stall),     32'(had == DEPTH));
         chk("drop_cnt",  32'(drop_cnt),  32'(drop_m));
         if (had != 0) begin
            chk("head_pc",   out_pc,   exp_q[0].pc);
            chk("head_inst", out_inst, exp_q[0].inst);
         end else begin
            chk("idle_pc",   out_pc,   32'd0);
            chk("idle_inst", out_inst, 32'd0);
         end
         if (flush) begin
            drop_m = (drop_m + had > DROP_MAX) ? DROP_MAX : drop_m + had;
            exp_q.delete();
         end else begin
            if (had != 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && had < DEPTH) exp_q.push_back('{pc: in_pc, inst: in_inst});
         end
      end
   end

   // Drive one cycle of inputs, return 1 time unit after the edge.
   task automatic cyc(input logic f, input logic iv, input logic [31:0] pc,
                      input logic [31:0] inst, input logic rdy);
      flush     = f;
      in_valid  = iv;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int d0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Single push after reset
      cyc(0, 1, 32'h0, 32'h24010005, 0);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_pc",    out_pc,          32'h0);
      chk("single_inst",  out_inst,        32'h24010005);
      chk("single_count", 32'(count),      32'd1);
      chk("single_stall", 32'(stall),      32'd0);
      cyc(1, 0, 0, 0, 0);

      // Fill and back-pressure; fetch re-presents 0x8 until accepted
      cyc(0, 1, 32'h0, 32'hA0, 0);
      cyc(0, 1, 32'h4, 32'hA4, 0);
      chk("fill_count", 32'(count), 32'd2);
      chk("fill_stall", 32'(stall), 32'd1);
      cyc(0, 1, 32'h8, 32'hA8, 0);
      chk("reject_count", 32'(count), 32'd2);
      cyc(0, 1, 32'h8, 32'hA8, 1);
      chk("pop_count", 32'(count), 32'd1);
      chk("pop_stall", 32'(stall), 32'd0);
      chk("pop_head",  out_pc,     32'h4);
      cyc(0, 1, 32'h8, 32'hA8, 0);
      cyc(0, 0, 0, 0, 1);
      chk("order_head", out_pc, 32'h8);
      cyc(0, 0, 0, 0, 1);

      // Streaming across pointer wrap
      for (int i = 0; i < 16; i++) cyc(0, 1, 32'(i * 4), $urandom, 1);
      cyc(0, 0, 0, 0, 1);

      // Flush while full; the flush-cycle word is discarded and not counted
      cyc(0, 1, 32'h10, 32'hB0, 0);
      cyc(0, 1, 32'h14, 32'hB4, 0);
      d0 = drop_m;
      cyc(1, 1, 32'h18, 32'hB8, 0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_count", 32'(count),     32'd0);
      chk("flush_stall", 32'(stall),     32'd0);
      chk("flush_drop",  32'(drop_cnt),  32'(d0 + 2));
      cyc(0, 1, 32'h100, 32'hC0, 0);
      chk("post_flush_pc", out_pc, 32'h100);

      // Simultaneous push and pop at count 1
      cyc(0, 1, 32'h104, 32'hC4, 1);
      chk("pushpop_count", 32'(count), 32'd1);
      chk("pushpop_head",  out_pc,     32'h104);
      cyc(1, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++)
         cyc(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
             {$urandom_range(0, 16383), 2'b00}, $urandom, $urandom_range(0, 1));

      // Drive the drop counter well past saturation
      for (int i = 0; i < 140; i++) begin
         cyc(0, 1, 32'h300, 32'hD0, 0);
         cyc(0, 1, 32'h304, 32'hD4, 0);
         cyc(1, 0, 0, 0, 0);
      end
      chk("drop_saturated", 32'(drop_cnt), 32'd255);

      // Asynchronous reset between edges with two entries held
      cyc(0, 1, 32'h400, 32'hE0, 0);
      cyc(0, 1, 32'h404, 32'hE4, 0);
      in_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_stall", 32'(stall),     32'd0);
      chk("arst_count", 32'(count),     32'd0);
      chk("arst_inst",  out_inst,       32'd0);
      chk("arst_drop",  32'(drop_cnt),  32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      cyc(0, 1, 32'h500, 32'hF0, 0);
      chk("restart_pc", out_pc, 32'h500);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
